rx_ds_char: RTL and testbench

Character-level receiver for the Data-Strobe link, the far end of the DS character transmitter. It decodes the per-clock dual-rail line (Rx1/Rx0) into 8-bit data characters and 2-bit link characters. It checks odd parity and line framing, and holds each decoded character in a one-entry output register with a valid/ready handshake toward the link layer.

---
 rtl/rx_ds_char.sv | 221 ++++++++++++++++++++++
 tb/tb_rx_ds_char.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ds_char.sv
// rx_ds_char: character-level receiver for the Data-Strobe link.
//
// Decodes the per-cycle dual-rail line symbol {Rx1,Rx0} into 8-bit data characters and 2-bit
// link characters. Each decoded character goes into a one-entry holding register that is
// drained with a valid/ready handshake.
//
// Ports:
//   RxClk        in   clock, rising edge
//   RxReset      in   synchronous active-high reset
//   Rx1, Rx0     in   line rails: 10 = bit 1, 01 = bit 0, 00 = idle gap, 11 = illegal
//   dat_o[7:0]   out  received character (link characters use [1:0], [7:2] = 0)
//   lchar_o      out  1 = link character, 0 = data character
//   valid_o      out  holding register contains an undelivered character
//   ready_i      in   consumer takes the character when valid_o is also high
//   parity_err_o out  one-cycle pulse, parity check failed
//   frame_err_o  out  one-cycle pulse, illegal symbol or premature idle
//   overrun_o    out  one-cycle pulse, character completed while holding register full (dropped)
//
// Configuration macro: RX_DS_PARITY_CHECK_EN. When undefined, the parity bit is discarded,
// no parity state is kept and parity_err_o is tied low.
//
// All outputs are registered; none depends combinationally on an input.

module rx_ds_char (
    input  logic       RxClk,
    input  logic       RxReset,
    input  logic       Rx1,
    input  logic       Rx0,
    output logic [7:0] dat_o,
    output logic       lchar_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    typedef enum logic [1:0] {StHunt, StIdle, StFlag, StData} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;             // payload bits still expected
    logic [7:0] sr_q, sr_d;               // payload shift register
    logic [7:0] sr_shift;
    logic       cur_lchar_q, cur_lchar_d; // flag of the character being received
    logic [7:0] dat_q, dat_d;
    logic       lchar_q, lchar_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       frame_hit;

`ifdef RX_DS_PARITY_CHECK_EN
    logic       p_q, p_d;
    logic       prev_xor_q, prev_xor_d;
    logic       skip_chk_q, skip_chk_d;
    logic       run_xor_q, run_xor_d;
    logic       parity_err_q, parity_err_d;
`endif

    logic sym_gap, sym_bit, sym_bad, bit_val;

    assign sym_gap = ~Rx1 & ~Rx0;
    assign sym_bit = Rx1 ^ Rx0;
    assign sym_bad = Rx1 & Rx0;
    assign bit_val = Rx1;

    // Payload arrives LSB first; shift in at the top of the character's own width so that
    // the first bit ends up in bit 0.
    assign sr_shift = cur_lchar_q ? {6'b0, bit_val, sr_q[1]} : {bit_val, sr_q[7:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        cur_lchar_d = cur_lchar_q;
        dat_d       = dat_q;
        lchar_d     = lchar_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_hit   = 1'b0;
`ifdef RX_DS_PARITY_CHECK_EN
        p_d          = p_q;
        prev_xor_d   = prev_xor_q;
        skip_chk_d   = skip_chk_q;
        run_xor_d    = run_xor_q;
        parity_err_d = 1'b0;
`endif

        // Consumer handshake; a delivery below in the same cycle overrides this.
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StHunt: begin
                if (sym_gap) begin
                    state_d = StIdle;
                end
            end

            StIdle: begin
                if (sym_bit) begin
`ifdef RX_DS_PARITY_CHECK_EN
                    p_d = bit_val;
`endif
                    state_d = StFlag;
                end else if (sym_bad) begin
                    frame_hit = 1'b1;
                end
            end

            StFlag: begin
                if (sym_bit) begin
                    cur_lchar_d = bit_val;
                    cnt_d       = bit_val ? 4'd2 : 4'd8;
                    sr_d        = 8'h00;
                    state_d     = StData;
`ifdef RX_DS_PARITY_CHECK_EN
                    run_xor_d = 1'b0;
                    if (skip_chk_q) begin
                        skip_chk_d = 1'b0;
                    end else if (!(p_q ^ bit_val ^ prev_xor_q)) begin
                        parity_err_d = 1'b1;
                        prev_xor_d   = 1'b0;
                        skip_chk_d   = 1'b1;
                        state_d      = StHunt;
                    end
`endif
                end else begin
                    frame_hit = 1'b1;
                end
            end

            StData: begin
                if (sym_bit) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q - 4'd1;
`ifdef RX_DS_PARITY_CHECK_EN
                    run_xor_d = run_xor_q ^ bit_val;
`endif
                    if (cnt_q == 4'd1) begin
`ifdef RX_DS_PARITY_CHECK_EN
                        prev_xor_d = run_xor_q ^ bit_val;
`endif
                        state_d = StHunt;
                        if (!valid_q || ready_i) begin
                            dat_d   = sr_shift;
                            lchar_d = cur_lchar_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else begin
                    frame_hit = 1'b1;
                end
            end

            default: state_d = StHunt;
        endcase

        frame_err_d = frame_hit;
        if (frame_hit) begin
            state_d = StHunt;
`ifdef RX_DS_PARITY_CHECK_EN
            prev_xor_d = 1'b0;
            skip_chk_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge RxClk) begin
        if (RxReset) begin
            state_q     <= StHunt;
            cnt_q       <= 4'd0;
            sr_q        <= 8'h00;
            cur_lchar_q <= 1'b0;
            dat_q       <= 8'h00;
            lchar_q     <= 1'b0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RX_DS_PARITY_CHECK_EN
            p_q          <= 1'b0;
            prev_xor_q   <= 1'b0;
            skip_chk_q   <= 1'b0;
            run_xor_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            cur_lchar_q <= cur_lchar_d;
            dat_q       <= dat_d;
            lchar_q     <= lchar_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef RX_DS_PARITY_CHECK_EN
            p_q          <= p_d;
            prev_xor_q   <= prev_xor_d;
            skip_chk_q   <= skip_chk_d;
            run_xor_q    <= run_xor_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign dat_o       = dat_q;
    assign lchar_o     = lchar_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
`ifdef RX_DS_PARITY_CHECK_EN
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rx_ds_char.sv
// Testbench for rx_ds_char: directed line symbols, a queue-based character model checked on
// every cycle after the first reset, and literal expectations at key points.

module tb_rx_ds_char;

    logic       RxClk = 1'b0;
    logic       RxReset;
    logic       Rx1, Rx0;
    logic [7:0] dat_o;
    logic       lchar_o, valid_o, ready_i;
    logic       parity_err_o, frame_err_o, overrun_o;

    int checks = 0;
    int errors = 0;

    rx_ds_char dut (
        .RxClk        (RxClk),
        .RxReset      (RxReset),
        .Rx1          (Rx1),
        .Rx0          (Rx0),
        .dat_o        (dat_o),
        .lchar_o      (lchar_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 RxClk = ~RxClk;

    // ---------------- model ----------------
    bit         armed = 1'b0;
    bit         m_hunt;
    bit         q[$];          // bits of the character in progress: P, F, payload...
    bit         m_flag;
    logic [7:0] m_dat;
    logic       m_lchar, m_valid, m_perr, m_ferr, m_ovr;
`ifdef RX_DS_PARITY_CHECK_EN
    bit         m_prev, m_skip;
`endif

    task automatic model_frame_err();
        m_ferr = 1'b1;
        m_hunt = 1'b1;
        q.delete();
`ifdef RX_DS_PARITY_CHECK_EN
        m_prev = 1'b0;
        m_skip = 1'b1;
`endif
    endtask

    task automatic model_step(input logic [1:0] s, input logic rst, input logic rdy);
        logic       was_valid;
        logic [7:0] val;
        int         ones;
        int         n;
        if (rst) begin
            armed = 1'b1;
            m_hunt = 1'b1;
            q.delete();
            m_dat = 8'h00; m_lchar = 1'b0; m_valid = 1'b0;
            m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
`ifdef RX_DS_PARITY_CHECK_EN
            m_prev = 1'b0; m_skip = 1'b0;
`endif
        end else begin
            was_valid = m_valid;
            m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            if (m_valid && rdy) m_valid = 1'b0;
            if (m_hunt) begin
                if (s == 2'b00) m_hunt = 1'b0;
            end else if (s == 2'b11 || (s == 2'b00 && q.size() != 0)) begin
                model_frame_err();
            end else if (s != 2'b00) begin
                q.push_back(s == 2'b10);
                if (q.size() == 2) begin
                    m_flag = q[1];
`ifdef RX_DS_PARITY_CHECK_EN
                    if (m_skip) begin
                        m_skip = 1'b0;
                    end else if ((q[0] ^ q[1] ^ m_prev) == 1'b0) begin
                        m_perr = 1'b1;
                        m_hunt = 1'b1;
                        q.delete();
                        m_prev = 1'b0;
                        m_skip = 1'b1;
                    end
`endif
                end else if (q.size() >= 3 && q.size() == (m_flag ? 4 : 10)) begin
                    n = q.size() - 2;
                    val = 8'h00;
                    ones = 0;
                    for (int i = 0; i < n; i++) begin
                        val[i] = q[i + 2];
                        ones += int'(q[i + 2]);
                    end
`ifdef RX_DS_PARITY_CHECK_EN
                    m_prev = ones[0];
`endif
                    if (!was_valid || rdy) begin
                        m_dat = val; m_lchar = m_flag; m_valid = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                    m_hunt = 1'b1;
                    q.delete();
                end
            end
        end
    endtask

    always @(posedge RxClk) begin
        model_step({Rx1, Rx0}, RxReset, ready_i);
        #1;
        if (armed) begin
            checks++;
            if (dat_o !== m_dat || lchar_o !== m_lchar || valid_o !== m_valid ||
                parity_err_o !== m_perr || frame_err_o !== m_ferr || overrun_o !== m_ovr) begin
                errors++;
                $display("FAIL cycle_model t=%0t: dut dat=%h l=%b v=%b pe=%b fe=%b ov=%b, model dat=%h l=%b v=%b pe=%b fe=%b ov=%b",
                         $time, dat_o, lchar_o, valid_o, parity_err_o, frame_err_o, overrun_o,
                         m_dat, m_lchar, m_valid, m_perr, m_ferr, m_ovr);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sym(input logic [1:0] s);
        @(negedge RxClk);
        {Rx1, Rx0} = s;
    endtask

    task automatic send_bit(input logic b);
        sym(b ? 2'b10 : 2'b01);
    endtask

    task automatic tick();
        @(posedge RxClk);
        #2;
    endtask

    task automatic send_char(input logic p, input logic f, input logic [7:0] pay);
        send_bit(p);
        send_bit(f);
        for (int i = 0; i < (f ? 2 : 8); i++) send_bit(pay[i]);
    endtask

    initial begin
        RxReset = 1'b1; Rx1 = 1'b0; Rx0 = 1'b0; ready_i = 1'b0;
        sym(2'b00); sym(2'b00); tick();
        check_lit("reset_valid", {7'b0, valid_o}, 8'h00);
        check_lit("reset_dat", dat_o, 8'h00);
        check_lit("reset_errs", {5'b0, parity_err_o, frame_err_o, overrun_o}, 8'h00);
        RxReset = 1'b0;

        // Data character A5, correct parity.
        sym(2'b00); send_char(1'b1, 1'b0, 8'hA5); tick();
        check_lit("a5_dat", dat_o, 8'hA5);
        check_lit("a5_valid_lchar", {6'b0, valid_o, lchar_o}, 8'h02);

        // Link character payload 2 delivered while the consumer is ready.
        ready_i = 1'b1;
        sym(2'b00); send_char(1'b0, 1'b1, 8'h02); tick();
        check_lit("l2_dat", dat_o, 8'h02);
        check_lit("l2_valid_lchar", {6'b0, valid_o, lchar_o}, 8'h03);

        // Same link character with the parity bit wrong (correct P is now 1).
        sym(2'b00); send_bit(1'b0); send_bit(1'b1); tick();
`ifdef RX_DS_PARITY_CHECK_EN
        check_lit("perr_pulse", {7'b0, parity_err_o}, 8'h01);
`endif
        send_bit(1'b0); send_bit(1'b1); tick();
`ifdef RX_DS_PARITY_CHECK_EN
        check_lit("perr_no_delivery", {6'b0, valid_o, lchar_o}, 8'h01);
`else
        check_lit("noparity_delivery", {6'b0, valid_o, lchar_o}, 8'h03);
`endif
        check_lit("perr_dat_kept", dat_o, 8'h02);

        // Illegal symbol at the third data bit.
        sym(2'b00); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        sym(2'b11); tick();
        check_lit("ferr_data", {7'b0, frame_err_o}, 8'h01);
        tick();
        check_lit("ferr_one_cycle", {7'b0, frame_err_o}, 8'h00);

        // Wrong parity, but the check is skipped after the frame error.
        sym(2'b00); send_char(1'b0, 1'b0, 8'h3C); tick();
        check_lit("skip_dat", dat_o, 8'h3C);
        check_lit("skip_valid", {7'b0, valid_o}, 8'h01);

        // Overrun: consumer stalled, A5 then 3C.
        sym(2'b00); tick();
        check_lit("drained", {7'b0, valid_o}, 8'h00);
        ready_i = 1'b0;
        send_char(1'b1, 1'b0, 8'hA5); sym(2'b00); send_char(1'b1, 1'b0, 8'h3C); tick();
        check_lit("ovr_pulse", {7'b0, overrun_o}, 8'h01);
        check_lit("ovr_dat_kept", dat_o, 8'hA5);
        check_lit("ovr_valid", {7'b0, valid_o}, 8'h01);
        ready_i = 1'b1; sym(2'b00); tick(); ready_i = 1'b0;
        check_lit("accept_clears", {7'b0, valid_o}, 8'h00);

        // Reset during the fifth data bit.
        ready_i = 1'b1;
        sym(2'b00); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        @(negedge RxClk); RxReset = 1'b1; {Rx1, Rx0} = 2'b10;
        tick();
        RxReset = 1'b0;
        check_lit("midreset_dat", dat_o, 8'h00);
        check_lit("midreset_flags", {4'b0, valid_o, lchar_o, frame_err_o, overrun_o}, 8'h00);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); tick();
        check_lit("leftover_ignored", {6'b0, valid_o, frame_err_o}, 8'h00);
        sym(2'b00); send_char(1'b1, 1'b0, 8'h5A); tick();
        check_lit("after_reset_dat", dat_o, 8'h5A);

        // Back-to-back link characters.
        sym(2'b00); send_char(1'b0, 1'b1, 8'h03); tick();
        check_lit("link3", {lchar_o, dat_o[6:0]}, 8'h83);
        sym(2'b00); send_char(1'b0, 1'b1, 8'h01); tick();
        check_lit("link1", {lchar_o, dat_o[6:0]}, 8'h81);

        // Illegal symbol in idle, premature idle after P.
        sym(2'b00); sym(2'b11); tick();
        check_lit("ferr_idle", {7'b0, frame_err_o}, 8'h01);
        sym(2'b00); send_bit(1'b1); sym(2'b00); tick();
        check_lit("ferr_flag_gap", {7'b0, frame_err_o}, 8'h01);
        sym(2'b00); send_char(1'b0, 1'b0, 8'hC3); tick();
        check_lit("skip2_dat", dat_o, 8'hC3);

        sym(2'b00); sym(2'b00); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
